// File: rtl/bchecc_pkg.sv
// Shared GF(2^13) definitions for the t=15 BCH decoder.
// Holds field constants, the Chien FSM encoding and elaboration-time GF helpers.
package bchecc_pkg;

   localparam int unsigned GF_M  = 13;
   localparam int unsigned T_MAX = 15;
   localparam int unsigned GF_N  = 8191;

   // Reduction taps of x^13+x^4+x^3+x+1 with x^13 implicit
   localparam logic [GF_M-1:0] GF_POLY = 13'h001B;
   localparam logic [GF_M-1:0] ALPHA   = 13'h0002;

   typedef logic [T_MAX-1:0][GF_M-1:0] lane_vec_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_INIT   = 2'd1,
      S_SEARCH = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                              input logic [GF_M-1:0] b);
      logic [GF_M-1:0] p;
      logic [GF_M-1:0] s;
      p = '0;
      s = a;
      for (int i = 0; i < GF_M; i++) begin
         if (b[i]) p = p ^ s;
         s = {s[GF_M-2:0], 1'b0} ^ (s[GF_M-1] ? GF_POLY : '0);
      end
      return p;
   endfunction

   // Square-and-multiply keeps elaboration cheap for large exponents
   function automatic logic [GF_M-1:0] gf_pow(input logic [GF_M-1:0] a,
                                              input int unsigned   e);
      logic [GF_M-1:0] r;
      int unsigned     er;
      er = e % GF_N;
      r  = GF_M'(1);
      for (int i = GF_M - 1; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (er[i]) r = gf_mul(r, a);
      end
      return r;
   endfunction

   // Lane j-1 gets alpha^(j*step)
   function automatic lane_vec_t lane_consts(input int unsigned step);
      lane_vec_t c;
      for (int unsigned j = 1; j <= T_MAX; j++) begin
         c[j-1] = gf_pow(ALPHA, (j * step) % GF_N);
      end
      return c;
   endfunction

endpackage

// File: rtl/bchecc_gfmult15.sv
// Fifteen independent GF(2^13) multipliers, one per locator lane.
module bchecc_gfmult15
   import bchecc_pkg::*;
(
   input  logic [T_MAX-1:0][GF_M-1:0] a_i,
   input  logic [T_MAX-1:0][GF_M-1:0] b_i,
   output logic [T_MAX-1:0][GF_M-1:0] p_o
);

   always_comb begin
      p_o = '0;
      for (int l = 0; l < T_MAX; l++) begin
         p_o[l] = gf_mul(a_i[l], b_i[l]);
      end
   end

endmodule

// File: rtl/bchecc_chien.sv
// Serial Chien search: evaluates sigma at one codeword position per clock and
// reports transmit-order error locations, with early stop once deg roots are found.
module bchecc_chien
   import bchecc_pkg::*;
#(
   parameter int unsigned CW_LEN = 4291
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [T_MAX*GF_M-1:0]   sigma_i,
   input  logic [3:0]              deg_i,
   output logic                    busy_o,
   output logic                    err_valid_o,
   output logic [GF_M-1:0]         err_loc_o,
   output logic [3:0]              err_cnt_o,
   output logic                    done_o,
   output logic                    fail_o
);

   localparam int unsigned     OFFSET = GF_N + 1 - CW_LEN;
   localparam lane_vec_t       INIT_C = lane_consts(OFFSET);
   localparam lane_vec_t       SRCH_C = lane_consts(1);
   localparam logic [GF_M-1:0] K_LAST = GF_M'(CW_LEN - 1);

   state_e          state_q;
   lane_vec_t       reg_q;
   lane_vec_t       mult_b;
   lane_vec_t       prod;
   logic [3:0]      deg_q;
   logic [3:0]      cnt_q;
   logic [3:0]      cnt_d;
   logic [GF_M-1:0] k_q;
   logic [GF_M-1:0] eval_sum;
   logic            hit;
   logic            last_pos;
   logic            busy_q;
   logic            err_valid_q;
   logic [GF_M-1:0] err_loc_q;
   logic            done_q;
   logic            fail_q;

   assign mult_b = (state_q == S_INIT) ? INIT_C : SRCH_C;

   bchecc_gfmult15 u_mult (
      .a_i (reg_q),
      .b_i (mult_b),
      .p_o (prod)
   );

   // sigma(alpha^(OFFSET+k)): implicit sigma0 = 1 plus all lane terms
   always_comb begin
      eval_sum = GF_M'(1);
      for (int l = 0; l < T_MAX; l++) begin
         eval_sum = eval_sum ^ reg_q[l];
      end
      hit      = (eval_sum == '0);
      cnt_d    = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
      last_pos = (k_q == K_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         reg_q       <= '0;
         deg_q       <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         err_valid_q <= 1'b0;
         err_loc_q   <= '0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         err_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  reg_q   <= sigma_i;
                  deg_q   <= deg_i;
                  cnt_q   <= '0;
                  fail_q  <= 1'b0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_INIT;
               end
            end
            S_INIT: begin
               reg_q <= prod;
               k_q   <= '0;
               if (deg_q == 4'd0) begin
                  done_q  <= 1'b1;
                  fail_q  <= (cnt_q != deg_q);
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               reg_q <= prod;
               k_q   <= k_q + GF_M'(1);
               if (hit) begin
                  err_valid_q <= 1'b1;
                  err_loc_q   <= k_q;
                  cnt_q       <= cnt_d;
               end
               // Stop on the last expected root or at the final position
               if ((hit && (cnt_d == deg_q)) || last_pos) begin
                  done_q  <= 1'b1;
                  fail_q  <= ((hit ? cnt_d : cnt_q) != deg_q);
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign err_valid_o = err_valid_q;
   assign err_loc_o   = err_loc_q;
   assign err_cnt_o   = cnt_q;
   assign done_o      = done_q;
   assign fail_o      = fail_q;

endmodule
